// File: rtl/cpu_sequencer_if.sv
// cpu_sequencer_if: ROM, GPR, ALU and status signals between the sequencer and the datapath.
interface cpu_sequencer_if;
    logic        run;
    logic        rom_en;
    logic [7:0]  rom_addr;
    logic [23:0] rom_data;
    logic [2:0]  gpr_r_addr_a;
    logic [2:0]  gpr_r_addr_b;
    logic [7:0]  gpr_r_data_a;
    logic [7:0]  gpr_r_data_b;
    logic        gpr_w_enable;
    logic [2:0]  gpr_w_addr;
    logic [7:0]  gpr_w_data;
    logic [2:0]  alu_operation;
    logic [7:0]  alu_A;
    logic [7:0]  alu_B;
    logic [7:0]  alu_C;
    logic [7:0]  pc;
    logic        zero;
    logic        halted;
    logic        illegal;
    modport master (
        input  run, rom_data, gpr_r_data_a, gpr_r_data_b, alu_C,
        output rom_en, rom_addr, gpr_r_addr_a, gpr_r_addr_b, gpr_w_enable, gpr_w_addr,
               gpr_w_data, alu_operation, alu_A, alu_B, pc, zero, halted, illegal
    );
    modport slave (
        output run, rom_data, gpr_r_data_a, gpr_r_data_b, alu_C,
        input  rom_en, rom_addr, gpr_r_addr_a, gpr_r_addr_b, gpr_w_enable, gpr_w_addr,
               gpr_w_data, alu_operation, alu_A, alu_B, pc, zero, halted, illegal
    );
endinterface

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: four-cycle fetch/decode/exec/writeback control unit with jumps, zero flag and halt.
module cpu_sequencer #(
    parameter logic [7:0] PC_RESET        = 8'h00,
    parameter bit         STOP_ON_ILLEGAL = 1'b0
) (
    input logic           clk,
    input logic           rst,
    cpu_sequencer_if.master bus
);
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, WB, HALT} state_t;
    state_t      r_state, w_next;
    logic [23:0] r_ir;
    logic [7:0]  r_pc, r_result;
    logic        r_zero, r_illegal;
    logic [3:0]  w_op;
    logic [7:0]  w_imm;
    logic        w_alu, w_alui, w_we, w_bad, w_stop, w_jump;
    assign w_op   = r_ir[23:20];
    assign w_imm  = r_ir[7:0];
    assign w_alu  = w_op == 4'h1;
    assign w_alui = w_op == 4'h2;
    assign w_bad  = w_op >= 4'h7 && w_op <= 4'hE;
    assign w_stop = w_op == 4'hF || (STOP_ON_ILLEGAL && w_bad);
    assign w_jump = w_op == 4'h5 || (w_op == 4'h6 && r_zero);
    assign w_we   = r_state == WB && w_op >= 4'h1 && w_op <= 4'h4;
    always_ff @(posedge clk or posedge rst)
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    always_comb begin
        w_next = r_state == IDLE   ? (bus.run ? FETCH : IDLE) :
                 r_state == FETCH  ? DECODE :
                 r_state == DECODE ? EXEC :
                 r_state == EXEC   ? WB :
                 r_state == WB     ? (w_stop ? HALT : FETCH) : HALT;
    end
    always_comb begin
        bus.rom_en        = r_state == FETCH;
        bus.rom_addr      = r_state == FETCH ? r_pc : 8'h00;
        bus.gpr_r_addr_a  = r_state == EXEC ? r_ir[16:14] : 3'd0;
        bus.gpr_r_addr_b  = r_state == EXEC ? r_ir[13:11] : 3'd0;
        bus.alu_operation = r_state == EXEC ? r_ir[10:8] : 3'd0;
        bus.alu_A         = r_state == EXEC ? bus.gpr_r_data_a : 8'h00;
        bus.alu_B         = r_state != EXEC ? 8'h00 : w_alu ? bus.gpr_r_data_b : w_alui ? w_imm : 8'h00;
        bus.gpr_w_enable  = w_we;
        bus.gpr_w_addr    = w_we ? r_ir[19:17] : 3'd0;
        bus.gpr_w_data    = w_we ? r_result : 8'h00;
        bus.pc            = r_pc;
        bus.zero          = r_zero;
        bus.halted        = r_state == HALT;
        bus.illegal       = r_illegal;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_pc      <= PC_RESET;
            r_ir      <= 24'h0;
            r_result  <= 8'h00;
            r_zero    <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            if (r_state == DECODE) r_ir <= bus.rom_data;
            if (r_state == EXEC) begin
                r_result <= (w_alu || w_alui) ? bus.alu_C :
                            w_op == 4'h3 ? w_imm :
                            w_op == 4'h4 ? bus.gpr_r_data_a : r_result;
                if (w_alu || w_alui) r_zero <= bus.alu_C == 8'h00;
            end
            if (r_state == WB) begin
                r_pc      <= w_stop ? r_pc : w_jump ? w_imm : r_pc + 8'd1;
                r_illegal <= r_illegal | w_bad;
            end
        end
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: scoreboard bench with ROM/GPR/ALU stubs; fetches and GPR writes are checked against queued expectations.
module tb_cpu_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic run = 1'b0;
    logic run1 = 1'b0;
    logic alu_zero = 1'b0;
    logic [23:0] rom [256];
    logic [23:0] r_romq;
    logic [7:0] gpr [8];
    logic [31:0] exp_f[$];
    logic [31:0] exp_w[$];
    int cyc = 0;
    int n_chk = 0;
    int n_pass = 0;
    always #5 clk = ~clk;
    cpu_sequencer_if bif ();
    cpu_sequencer_if bif1 ();
    cpu_sequencer #(.PC_RESET(8'h00), .STOP_ON_ILLEGAL(1'b0)) u_dut (.clk(clk), .rst(rst), .bus(bif));
    cpu_sequencer #(.PC_RESET(8'h00), .STOP_ON_ILLEGAL(1'b1)) u_dut1 (.clk(clk), .rst(rst), .bus(bif1));
    always @(posedge clk) if (bif.rom_en) r_romq <= rom[bif.rom_addr];
    assign bif.run          = run;
    assign bif.rom_data     = r_romq;
    assign bif.gpr_r_data_a = gpr[bif.gpr_r_addr_a];
    assign bif.gpr_r_data_b = gpr[bif.gpr_r_addr_b];
    assign bif.alu_C        = alu_zero ? 8'h00 : bif.alu_A + bif.alu_B;
    assign bif1.run          = run1;
    assign bif1.rom_data     = 24'h900000;
    assign bif1.gpr_r_data_a = 8'h00;
    assign bif1.gpr_r_data_b = 8'h00;
    assign bif1.alu_C        = 8'h00;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [23:0] ins(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] ra,
                                        input logic [2:0] rb, input logic [2:0] aop, input logic [7:0] imm);
        return {op, rd, ra, rb, aop, imm};
    endfunction

    task automatic ef(input int c, input logic [7:0] a);
        exp_f.push_back({c[23:0], a});
    endtask

    task automatic ew(input int c, input logic [2:0] a, input logic [7:0] d);
        exp_w.push_back({c[20:0], a, d});
    endtask

    task automatic step(input int n);
        logic [31:0] e;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cyc++;
            if (bif.rom_en) begin
                if (exp_f.size() == 0) chk("fetch_unexpected", {cyc[23:0], bif.rom_addr}, 32'h0);
                else begin
                    e = exp_f.pop_front();
                    chk("fetch", {cyc[23:0], bif.rom_addr}, e);
                end
            end
            if (bif.gpr_w_enable) begin
                if (exp_w.size() == 0) chk("write_unexpected", {cyc[20:0], bif.gpr_w_addr, bif.gpr_w_data}, 32'h0);
                else begin
                    e = exp_w.pop_front();
                    chk("write", {cyc[20:0], bif.gpr_w_addr, bif.gpr_w_data}, e);
                end
            end
            if (bif1.gpr_w_enable) chk("write1_unexpected", 32'd1, 32'd0);
        end
    endtask

    task automatic drained(input string tag);
        chk({tag, "_fetch_q"}, exp_f.size(), 0);
        chk({tag, "_write_q"}, exp_w.size(), 0);
        exp_f.delete();
        exp_w.delete();
    endtask

    task automatic reset_all();
        @(negedge clk);
        run = 1'b0;
        run1 = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 256; i++) rom[i] = 24'h0;
    endtask

    task automatic go();
        run = 1'b1;
        cyc = 1;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) gpr[i] = 8'(8'h10 + i);
        gpr[2] = 8'd7;
        gpr[4] = 8'd9;
        reset_all();
        chk("rst_pc", bif.pc, 8'h00);
        chk("rst_zero", bif.zero, 0);
        chk("rst_halted", bif.halted, 0);
        chk("rst_illegal", bif.illegal, 0);
        chk("rst_rom_en", bif.rom_en, 0);
        chk("rst_gpr_w_enable", bif.gpr_w_enable, 0);
        // LDI then HALT
        rom[0] = ins(4'h3, 3'd3, 3'd0, 3'd0, 3'd0, 8'h5A);
        rom[1] = ins(4'hF, 3'd0, 3'd0, 3'd0, 3'd0, 8'h00);
        ef(2, 8'h00); ef(6, 8'h01); ew(5, 3'd3, 8'h5A);
        go();
        step(11);
        chk("t1_halted", bif.halted, 1);
        chk("t1_pc", bif.pc, 8'h01);
        chk("t1_rom_en", bif.rom_en, 0);
        drained("t1");
        // ALU r1 = r2 op r4
        reset_all();
        rom[0] = ins(4'h1, 3'd1, 3'd2, 3'd4, 3'b010, 8'h00);
        rom[1] = ins(4'hF, 3'd0, 3'd0, 3'd0, 3'd0, 8'h00);
        ef(2, 8'h00); ef(6, 8'h01); ew(5, 3'd1, 8'd16);
        go();
        step(3);
        chk("t2_alu_op", bif.alu_operation, 3'd2);
        chk("t2_alu_A", bif.alu_A, 8'd7);
        chk("t2_alu_B", bif.alu_B, 8'd9);
        step(8);
        chk("t2_zero", bif.zero, 0);
        chk("t2_halted", bif.halted, 1);
        drained("t2");
        // ALUI gives zero, JZ taken
        reset_all();
        alu_zero = 1'b1;
        rom[0]    = ins(4'h2, 3'd5, 3'd2, 3'd0, 3'd0, 8'h03);
        rom[1]    = ins(4'h6, 3'd0, 3'd0, 3'd0, 3'd0, 8'h20);
        rom[8'h20] = ins(4'hF, 3'd0, 3'd0, 3'd0, 3'd0, 8'h00);
        ef(2, 8'h00); ef(6, 8'h01); ef(10, 8'h20); ew(5, 3'd5, 8'h00);
        go();
        step(3);
        chk("t3a_alu_B_imm", bif.alu_B, 8'h03);
        step(1);
        chk("t3a_zero", bif.zero, 1);
        step(10);
        chk("t3a_pc", bif.pc, 8'h20);
        chk("t3a_halted", bif.halted, 1);
        drained("t3a");
        // ALUI nonzero, JZ not taken
        reset_all();
        alu_zero = 1'b0;
        rom[0] = ins(4'h2, 3'd5, 3'd2, 3'd0, 3'd0, 8'h03);
        rom[1] = ins(4'h6, 3'd0, 3'd0, 3'd0, 3'd0, 8'h20);
        rom[2] = ins(4'hF, 3'd0, 3'd0, 3'd0, 3'd0, 8'h00);
        ef(2, 8'h00); ef(6, 8'h01); ef(10, 8'h02); ew(5, 3'd5, 8'd10);
        go();
        step(14);
        chk("t3b_zero", bif.zero, 0);
        chk("t3b_pc", bif.pc, 8'h02);
        chk("t3b_halted", bif.halted, 1);
        drained("t3b");
        // JMP to 0xFF holding NOP wraps to 0x00
        reset_all();
        rom[0] = ins(4'h5, 3'd0, 3'd0, 3'd0, 3'd0, 8'hFF);
        ef(2, 8'h00); ef(6, 8'hFF); ef(10, 8'h00); ef(14, 8'hFF);
        go();
        step(15);
        chk("t4_pc", bif.pc, 8'hFF);
        chk("t4_halted", bif.halted, 0);
        drained("t4");
        // illegal opcode 9 on both parameter settings
        reset_all();
        rom[0] = ins(4'h9, 3'd2, 3'd1, 3'd1, 3'd1, 8'h44);
        rom[1] = ins(4'hF, 3'd0, 3'd0, 3'd0, 3'd0, 8'h00);
        ef(2, 8'h00); ef(6, 8'h01);
        go();
        run1 = 1'b1;
        step(3);
        chk("t5_illegal_early", bif.illegal, 0);
        step(2);
        chk("t5_illegal", bif.illegal, 1);
        chk("t5_halted_early", bif.halted, 0);
        chk("t5s_halted", bif1.halted, 1);
        step(6);
        chk("t5_pc", bif.pc, 8'h01);
        chk("t5_halted", bif.halted, 1);
        chk("t5_illegal_hold", bif.illegal, 1);
        chk("t5s_illegal", bif1.illegal, 1);
        chk("t5s_pc", bif1.pc, 8'h00);
        chk("t5s_rom_en", bif1.rom_en, 0);
        drained("t5");
        // async reset during EXEC of an LDI
        reset_all();
        rom[1] = ins(4'h3, 3'd6, 3'd5, 3'd0, 3'd3, 8'h77);
        ef(2, 8'h00); ef(6, 8'h01);
        go();
        step(7);
        chk("t6_exec_ra", bif.gpr_r_addr_a, 3'd5);
        chk("t6_exec_op", bif.alu_operation, 3'd3);
        chk("t6_exec_pc", bif.pc, 8'h01);
        #2 rst = 1'b1;
        #1;
        chk("t6_async_ra", bif.gpr_r_addr_a, 3'd0);
        chk("t6_async_op", bif.alu_operation, 3'd0);
        chk("t6_async_pc", bif.pc, 8'h00);
        run = 1'b0;
        step(3);
        rst = 1'b0;
        step(4);
        chk("t6_idle_rom_en", bif.rom_en, 0);
        chk("t6_idle_pc", bif.pc, 8'h00);
        drained("t6");
        ef(2, 8'h00);
        go();
        step(1);
        drained("t6_rerun");
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
